axi_rr_arbiter: RTL and testbench

- Shares one AXI4 master port to the memory/peripheral bus between two requesters: IFU (read-only) and EXU (read and write).
- Reads are granted round-robin and held for the whole burst, with a beat counter that checks `rlast` against `arlen`.
- Writes come only from the EXU and run on an independent write path, so one read burst and one write may be outstanding together.
- Sits between the IFU/EXU AXI master ports and the top-level bus/xbar.

---
 rtl/axi_pkg.sv | 45 ++++
 rtl/axi_rr_arbiter_if.sv | 158 +++++++++++++++
 rtl/rr_pick2.sv | 31 +++
 rtl/axi_rr_arbiter.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_axi_rr_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_pkg
//  Description : Shared types for the two-requester AXI read/write arbiter:
//                FSM state encodings, AXI response codes, grant encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package axi_pkg;

    // Read-side arbiter states
    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    // Write-side arbiter states
    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_BUSY = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    // Which requester owns the read path
    typedef enum logic {
        GRANT_IFU = 1'b0,
        GRANT_EXU = 1'b1
    } grant_t;

    // AXI response codes
    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_exokay = 2'b01;
    localparam logic [1:0] c_resp_slverr = 2'b10;
    localparam logic [1:0] c_resp_decerr = 2'b11;

    // Width of the AXI burst-length field
    localparam int LEN_W = 8;

    // The requester that did not win last time
    function automatic grant_t rr_other(input grant_t g);
        return (g == GRANT_IFU) ? GRANT_EXU : GRANT_IFU;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_rr_arbiter_if
//  Description : Signal bundle of the arbiter: IFU/EXU requester ports, the
//                shared bus master port and the protocol-error pulse.
//                'slave' is the arbiter's view, 'master' the surroundings.
//  Revision    : 1.0  initial release
// ============================================================================
interface axi_rr_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
);
    localparam int STRB_W = DATA_W / 8;

    // IFU read address
    logic              ifu_arvalid_i;
    logic [ADDR_W-1:0] ifu_araddr_i;
    logic [ID_W-1:0]   ifu_arid_i;
    logic [7:0]        ifu_arlen_i;
    logic [2:0]        ifu_arsize_i;
    logic [1:0]        ifu_arburst_i;
    logic              ifu_arready_o;
    // EXU read address
    logic              exu_arvalid_i;
    logic [ADDR_W-1:0] exu_araddr_i;
    logic [ID_W-1:0]   exu_arid_i;
    logic [7:0]        exu_arlen_i;
    logic [2:0]        exu_arsize_i;
    logic [1:0]        exu_arburst_i;
    logic              exu_arready_o;
    // Bus read address
    logic              arvalid_o;
    logic [ADDR_W-1:0] araddr_o;
    logic [ID_W-1:0]   arid_o;
    logic [7:0]        arlen_o;
    logic [2:0]        arsize_o;
    logic [1:0]        arburst_o;
    logic              arready_i;
    // Bus read data
    logic              rvalid_i;
    logic [DATA_W-1:0] rdata_i;
    logic [1:0]        rresp_i;
    logic              rlast_i;
    logic [ID_W-1:0]   rid_i;
    logic              rready_o;
    // Routed read data
    logic              ifu_rvalid_o;
    logic [DATA_W-1:0] ifu_rdata_o;
    logic [1:0]        ifu_rresp_o;
    logic              ifu_rlast_o;
    logic [ID_W-1:0]   ifu_rid_o;
    logic              ifu_rready_i;
    logic              exu_rvalid_o;
    logic [DATA_W-1:0] exu_rdata_o;
    logic [1:0]        exu_rresp_o;
    logic              exu_rlast_o;
    logic [ID_W-1:0]   exu_rid_o;
    logic              exu_rready_i;
    // EXU write address
    logic              exu_awvalid_i;
    logic [ADDR_W-1:0] exu_awaddr_i;
    logic [ID_W-1:0]   exu_awid_i;
    logic [7:0]        exu_awlen_i;
    logic [2:0]        exu_awsize_i;
    logic [1:0]        exu_awburst_i;
    logic              exu_awready_o;
    // Bus write address
    logic              awvalid_o;
    logic [ADDR_W-1:0] awaddr_o;
    logic [ID_W-1:0]   awid_o;
    logic [7:0]        awlen_o;
    logic [2:0]        awsize_o;
    logic [1:0]        awburst_o;
    logic              awready_i;
    // EXU write data
    logic              exu_wvalid_i;
    logic [DATA_W-1:0] exu_wdata_i;
    logic [STRB_W-1:0] exu_wstrb_i;
    logic              exu_wlast_i;
    logic              exu_wready_o;
    // Bus write data
    logic              wvalid_o;
    logic [DATA_W-1:0] wdata_o;
    logic [STRB_W-1:0] wstrb_o;
    logic              wlast_o;
    logic              wready_i;
    // Bus write response
    logic              bvalid_i;
    logic [1:0]        bresp_i;
    logic [ID_W-1:0]   bid_i;
    logic              bready_o;
    // Routed write response
    logic              exu_bvalid_o;
    logic [1:0]        exu_bresp_o;
    logic [ID_W-1:0]   exu_bid_o;
    logic              exu_bready_i;
    // Burst-length protocol violation
    logic              rd_err_o;

    modport slave (
        input  ifu_arvalid_i, ifu_araddr_i, ifu_arid_i, ifu_arlen_i, ifu_arsize_i, ifu_arburst_i,
        output ifu_arready_o,
        input  exu_arvalid_i, exu_araddr_i, exu_arid_i, exu_arlen_i, exu_arsize_i, exu_arburst_i,
        output exu_arready_o,
        output arvalid_o, araddr_o, arid_o, arlen_o, arsize_o, arburst_o,
        input  arready_i,
        input  rvalid_i, rdata_i, rresp_i, rlast_i, rid_i,
        output rready_o,
        output ifu_rvalid_o, ifu_rdata_o, ifu_rresp_o, ifu_rlast_o, ifu_rid_o,
        input  ifu_rready_i,
        output exu_rvalid_o, exu_rdata_o, exu_rresp_o, exu_rlast_o, exu_rid_o,
        input  exu_rready_i,
        input  exu_awvalid_i, exu_awaddr_i, exu_awid_i, exu_awlen_i, exu_awsize_i, exu_awburst_i,
        output exu_awready_o,
        output awvalid_o, awaddr_o, awid_o, awlen_o, awsize_o, awburst_o,
        input  awready_i,
        input  exu_wvalid_i, exu_wdata_i, exu_wstrb_i, exu_wlast_i,
        output exu_wready_o,
        output wvalid_o, wdata_o, wstrb_o, wlast_o,
        input  wready_i,
        input  bvalid_i, bresp_i, bid_i,
        output bready_o,
        output exu_bvalid_o, exu_bresp_o, exu_bid_o,
        input  exu_bready_i,
        output rd_err_o
    );

    modport master (
        output ifu_arvalid_i, ifu_araddr_i, ifu_arid_i, ifu_arlen_i, ifu_arsize_i, ifu_arburst_i,
        input  ifu_arready_o,
        output exu_arvalid_i, exu_araddr_i, exu_arid_i, exu_arlen_i, exu_arsize_i, exu_arburst_i,
        input  exu_arready_o,
        input  arvalid_o, araddr_o, arid_o, arlen_o, arsize_o, arburst_o,
        output arready_i,
        output rvalid_i, rdata_i, rresp_i, rlast_i, rid_i,
        input  rready_o,
        input  ifu_rvalid_o, ifu_rdata_o, ifu_rresp_o, ifu_rlast_o, ifu_rid_o,
        output ifu_rready_i,
        input  exu_rvalid_o, exu_rdata_o, exu_rresp_o, exu_rlast_o, exu_rid_o,
        output exu_rready_i,
        output exu_awvalid_i, exu_awaddr_i, exu_awid_i, exu_awlen_i, exu_awsize_i, exu_awburst_i,
        input  exu_awready_o,
        input  awvalid_o, awaddr_o, awid_o, awlen_o, awsize_o, awburst_o,
        output awready_i,
        output exu_wvalid_i, exu_wdata_i, exu_wstrb_i, exu_wlast_i,
        input  exu_wready_o,
        input  wvalid_o, wdata_o, wstrb_o, wlast_o,
        output wready_i,
        output bvalid_i, bresp_i, bid_i,
        input  bready_o,
        input  exu_bvalid_o, exu_bresp_o, exu_bid_o,
        output exu_bready_i,
        input  rd_err_o
    );

endinterface
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick2
//  Description : Combinational two-way round-robin picker. On contention the
//                requester that did not win last time is chosen.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick2
    import axi_pkg::*;
(
    input  logic   i_req_ifu,
    input  logic   i_req_exu,
    input  grant_t i_last_grant,
    output logic   o_valid,
    output grant_t o_grant
);

    // Pick the sole requester, or alternate when both are asking
    always_comb begin
        o_grant = GRANT_IFU;
        if (i_req_ifu && i_req_exu) begin
            o_grant = rr_other(i_last_grant);
        end else if (i_req_exu) begin
            o_grant = GRANT_EXU;
        end
    end

    assign o_valid = i_req_ifu | i_req_exu;

endmodule
`default_nettype wire

// File: rtl/axi_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axi_rr_arbiter
//  Description : Shares one AXI4 master port between IFU (read-only) and EXU
//                (read/write). Reads are granted round-robin and held for the
//                whole burst; EXU writes use an independent path. All bus
//                signals are pure muxes steered by registered state.
//  Revision    : 1.0  initial release
// ============================================================================
module axi_rr_arbiter
    import axi_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    axi_rr_arbiter_if.slave axi
);

    // ------------------------------------------------------------------
    // Read path state
    // ------------------------------------------------------------------
    rd_state_t        r_rd_state;
    rd_state_t        w_rd_state_nxt;
    grant_t           r_grant;
    grant_t           w_grant_nxt;
    grant_t           r_last_grant;
    grant_t           w_last_grant_nxt;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] w_len_nxt;
    logic [LEN_W-1:0] r_beat;
    logic [LEN_W-1:0] w_beat_nxt;

    logic             w_pick_valid;
    grant_t           w_pick_grant;
    logic             w_sel_arvalid;
    logic [LEN_W-1:0] w_sel_arlen;
    logic             w_sel_rready;
    logic             w_ar_hs;
    logic             w_r_hs;

    rr_pick2 u_pick (
        .i_req_ifu    (axi.ifu_arvalid_i),
        .i_req_exu    (axi.exu_arvalid_i),
        .i_last_grant (r_last_grant),
        .o_valid      (w_pick_valid),
        .o_grant      (w_pick_grant)
    );

    assign w_sel_arvalid = (r_grant == GRANT_EXU) ? axi.exu_arvalid_i : axi.ifu_arvalid_i;
    assign w_sel_arlen   = (r_grant == GRANT_EXU) ? axi.exu_arlen_i   : axi.ifu_arlen_i;
    assign w_sel_rready  = (r_grant == GRANT_EXU) ? axi.exu_rready_i  : axi.ifu_rready_i;
    assign w_ar_hs       = (r_rd_state == R_ADDR) && w_sel_arvalid && axi.arready_i;
    assign w_r_hs        = (r_rd_state == R_DATA) && axi.rvalid_i && w_sel_rready;

    // Read FSM and grant/beat bookkeeping registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_state   <= R_IDLE;
            r_grant      <= GRANT_IFU;
            r_last_grant <= GRANT_EXU;
            r_len        <= '0;
            r_beat       <= '0;
        end else begin
            r_rd_state   <= w_rd_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_len        <= w_len_nxt;
            r_beat       <= w_beat_nxt;
        end
    end

    // Read FSM next state: grant in idle, hold through the burst, release on rlast
    always_comb begin
        w_rd_state_nxt   = r_rd_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        w_len_nxt        = r_len;
        w_beat_nxt       = r_beat;
        case (r_rd_state)
            R_IDLE: begin
                if (w_pick_valid) begin
                    w_grant_nxt    = w_pick_grant;
                    w_rd_state_nxt = R_ADDR;
                end
            end
            R_ADDR: begin
                if (w_ar_hs) begin
                    w_len_nxt      = w_sel_arlen;
                    w_beat_nxt     = '0;
                    w_rd_state_nxt = R_DATA;
                end
            end
            R_DATA: begin
                if (w_r_hs) begin
                    w_beat_nxt = r_beat + 8'd1;
                    // A wrong-length burst is only flagged; release still waits for rlast
                    if (axi.rlast_i) begin
                        w_last_grant_nxt = r_grant;
                        w_rd_state_nxt   = R_IDLE;
                    end
                end
            end
            default: begin
                w_rd_state_nxt = R_IDLE;
            end
        endcase
    end

    // Read channel routing; the non-granted requester sees all zeros
    always_comb begin
        axi.ifu_arready_o = 1'b0;
        axi.exu_arready_o = 1'b0;
        axi.arvalid_o     = 1'b0;
        axi.araddr_o      = '0;
        axi.arid_o        = '0;
        axi.arlen_o       = '0;
        axi.arsize_o      = '0;
        axi.arburst_o     = '0;
        axi.rready_o      = 1'b0;
        axi.ifu_rvalid_o  = 1'b0;
        axi.ifu_rdata_o   = '0;
        axi.ifu_rresp_o   = '0;
        axi.ifu_rlast_o   = 1'b0;
        axi.ifu_rid_o     = '0;
        axi.exu_rvalid_o  = 1'b0;
        axi.exu_rdata_o   = '0;
        axi.exu_rresp_o   = '0;
        axi.exu_rlast_o   = 1'b0;
        axi.exu_rid_o     = '0;
        axi.rd_err_o      = 1'b0;
        case (r_rd_state)
            R_ADDR: begin
                if (r_grant == GRANT_EXU) begin
                    axi.arvalid_o     = axi.exu_arvalid_i;
                    axi.araddr_o      = axi.exu_araddr_i;
                    axi.arid_o        = axi.exu_arid_i;
                    axi.arlen_o       = axi.exu_arlen_i;
                    axi.arsize_o      = axi.exu_arsize_i;
                    axi.arburst_o     = axi.exu_arburst_i;
                    axi.exu_arready_o = axi.arready_i;
                end else begin
                    axi.arvalid_o     = axi.ifu_arvalid_i;
                    axi.araddr_o      = axi.ifu_araddr_i;
                    axi.arid_o        = axi.ifu_arid_i;
                    axi.arlen_o       = axi.ifu_arlen_i;
                    axi.arsize_o      = axi.ifu_arsize_i;
                    axi.arburst_o     = axi.ifu_arburst_i;
                    axi.ifu_arready_o = axi.arready_i;
                end
            end
            R_DATA: begin
                axi.rready_o = w_sel_rready;
                // Last beat must coincide with beat index == arlen
                axi.rd_err_o = w_r_hs && (axi.rlast_i ? (r_beat != r_len) : (r_beat == r_len));
                if (r_grant == GRANT_EXU) begin
                    axi.exu_rvalid_o = axi.rvalid_i;
                    axi.exu_rdata_o  = axi.rdata_i;
                    axi.exu_rresp_o  = axi.rresp_i;
                    axi.exu_rlast_o  = axi.rlast_i;
                    axi.exu_rid_o    = axi.rid_i;
                end else begin
                    axi.ifu_rvalid_o = axi.rvalid_i;
                    axi.ifu_rdata_o  = axi.rdata_i;
                    axi.ifu_rresp_o  = axi.rresp_i;
                    axi.ifu_rlast_o  = axi.rlast_i;
                    axi.ifu_rid_o    = axi.rid_i;
                end
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Write path (EXU only, independent of the read path)
    // ------------------------------------------------------------------
    wr_state_t r_wr_state;
    wr_state_t w_wr_state_nxt;
    logic      r_aw_done;
    logic      w_aw_done_nxt;
    logic      r_w_done;
    logic      w_w_done_nxt;
    logic      w_aw_hs;
    logic      w_wlast_hs;
    logic      w_b_hs;

    assign w_aw_hs    = (r_wr_state == W_BUSY) && !r_aw_done && axi.exu_awvalid_i && axi.awready_i;
    assign w_wlast_hs = (r_wr_state == W_BUSY) && !r_w_done && axi.exu_wvalid_i && axi.wready_i
                        && axi.exu_wlast_i;
    assign w_b_hs     = (r_wr_state == W_RESP) && axi.bvalid_i && axi.exu_bready_i;

    // Write FSM and channel-completion flags
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_state <= W_IDLE;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_aw_done  <= w_aw_done_nxt;
            r_w_done   <= w_w_done_nxt;
        end
    end

    // Write FSM next state: AW and W may finish in either order or together
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_aw_done_nxt  = r_aw_done;
        w_w_done_nxt   = r_w_done;
        case (r_wr_state)
            W_IDLE: begin
                w_aw_done_nxt = 1'b0;
                w_w_done_nxt  = 1'b0;
                if (axi.exu_awvalid_i) begin
                    w_wr_state_nxt = W_BUSY;
                end
            end
            W_BUSY: begin
                w_aw_done_nxt = r_aw_done | w_aw_hs;
                w_w_done_nxt  = r_w_done | w_wlast_hs;
                if (w_aw_done_nxt && w_w_done_nxt) begin
                    w_wr_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                if (w_b_hs) begin
                    w_wr_state_nxt = W_IDLE;
                end
            end
            default: begin
                w_wr_state_nxt = W_IDLE;
            end
        endcase
    end

    // Write channel routing; AW and W run together so slave ordering cannot deadlock
    always_comb begin
        axi.exu_awready_o = 1'b0;
        axi.awvalid_o     = 1'b0;
        axi.awaddr_o      = '0;
        axi.awid_o        = '0;
        axi.awlen_o       = '0;
        axi.awsize_o      = '0;
        axi.awburst_o     = '0;
        axi.exu_wready_o  = 1'b0;
        axi.wvalid_o      = 1'b0;
        axi.wdata_o       = '0;
        axi.wstrb_o       = '0;
        axi.wlast_o       = 1'b0;
        axi.bready_o      = 1'b0;
        axi.exu_bvalid_o  = 1'b0;
        axi.exu_bresp_o   = '0;
        axi.exu_bid_o     = '0;
        case (r_wr_state)
            W_BUSY: begin
                if (!r_aw_done) begin
                    axi.awvalid_o     = axi.exu_awvalid_i;
                    axi.awaddr_o      = axi.exu_awaddr_i;
                    axi.awid_o        = axi.exu_awid_i;
                    axi.awlen_o       = axi.exu_awlen_i;
                    axi.awsize_o      = axi.exu_awsize_i;
                    axi.awburst_o     = axi.exu_awburst_i;
                    axi.exu_awready_o = axi.awready_i;
                end
                if (!r_w_done) begin
                    axi.wvalid_o     = axi.exu_wvalid_i;
                    axi.wdata_o      = axi.exu_wdata_i;
                    axi.wstrb_o      = axi.exu_wstrb_i;
                    axi.wlast_o      = axi.exu_wlast_i;
                    axi.exu_wready_o = axi.wready_i;
                end
            end
            W_RESP: begin
                axi.exu_bvalid_o = axi.bvalid_i;
                axi.exu_bresp_o  = axi.bresp_i;
                axi.exu_bid_o    = axi.bid_i;
                axi.bready_o     = axi.exu_bready_i;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_rr_arbiter
//  Description : Directed self-checking bench for axi_rr_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axi_rr_arbiter;
    import axi_pkg::*;

    logic clock;
    logic reset;
    int   n_total;
    int   n_bad;
    int   errs;
    int   errs_w;

    axi_rr_arbiter_if #(.ADDR_W(32), .DATA_W(64), .ID_W(4)) axi ();

    axi_rr_arbiter dut (
        .clock (clock),
        .reset (reset),
        .axi   (axi)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ar(input bit exu, input bit v, input logic [31:0] addr, input logic [7:0] len);
        if (exu) begin
            axi.exu_arvalid_i = v;     axi.exu_araddr_i = addr; axi.exu_arid_i = 4'h9;
            axi.exu_arlen_i   = len;   axi.exu_arsize_i = 3'd3; axi.exu_arburst_i = 2'b01;
        end else begin
            axi.ifu_arvalid_i = v;     axi.ifu_araddr_i = addr; axi.ifu_arid_i = 4'h3;
            axi.ifu_arlen_i   = len;   axi.ifu_arsize_i = 3'd3; axi.ifu_arburst_i = 2'b01;
        end
    endtask

    // One read burst by the expected winner; arready held low for ar_wait cycles
    task automatic rd_burst(input bit exu, input logic [7:0] len, input int n_beats,
                            input int ar_wait, input logic [31:0] addr, output int n_err);
        logic [63:0] d;
        logic        exp_err;
        set_ar(exu, 1'b1, addr, len);
        axi.arready_i = 1'b0;
        step();
        for (int k = 0; k <= ar_wait; k++) begin
            axi.arready_i = (k == ar_wait);
            #1;
            check_val("ar_valid", axi.arvalid_o, 1);
            check_val("ar_addr", axi.araddr_o, addr);
            check_val("ar_len", axi.arlen_o, len);
            check_val("ar_ready_own", exu ? axi.exu_arready_o : axi.ifu_arready_o, axi.arready_i);
            check_val("ar_ready_other", exu ? axi.ifu_arready_o : axi.exu_arready_o, 0);
            step();
        end
        set_ar(exu, 1'b0, addr, len);
        axi.arready_i    = 1'b0;
        axi.ifu_rready_i = 1'b1;
        axi.exu_rready_i = 1'b1;
        n_err = 0;
        for (int b = 0; b < n_beats; b++) begin
            d = {addr, 32'(b) + 32'hBEE0_0000};
            axi.rvalid_i = 1'b1;
            axi.rdata_i  = d;
            axi.rresp_i  = c_resp_okay;
            axi.rlast_i  = (b == n_beats - 1);
            axi.rid_i    = exu ? 4'h9 : 4'h3;
            #1;
            exp_err = axi.rlast_i ? (b != int'(len)) : (b == int'(len));
            check_val("ar_dropped", axi.arvalid_o, 0);
            check_val("r_valid_own", exu ? axi.exu_rvalid_o : axi.ifu_rvalid_o, 1);
            check_val("r_data_own", exu ? axi.exu_rdata_o : axi.ifu_rdata_o, d);
            check_val("r_last_own", exu ? axi.exu_rlast_o : axi.ifu_rlast_o, axi.rlast_i);
            check_val("r_id_own", exu ? axi.exu_rid_o : axi.ifu_rid_o, exu ? 4'h9 : 4'h3);
            check_val("r_valid_other", exu ? axi.ifu_rvalid_o : axi.exu_rvalid_o, 0);
            check_val("r_ready_bus", axi.rready_o, 1);
            check_val("rd_err", axi.rd_err_o, exp_err);
            if (axi.rd_err_o) n_err++;
            step();
        end
        axi.rlast_i = 1'b0;
        #1;
        check_val("released_rready", axi.rready_o, 0);
        check_val("released_rvalid", exu ? axi.exu_rvalid_o : axi.ifu_rvalid_o, 0);
        axi.rvalid_i = 1'b0;
    endtask

    // Single-beat EXU write whose W handshake precedes AW by aw_delay cycles
    task automatic wr_txn(input int aw_delay, input logic [31:0] addr, input logic [3:0] id);
        axi.exu_awvalid_i = 1'b1; axi.exu_awaddr_i = addr; axi.exu_awid_i = id;
        axi.exu_awlen_i   = 8'd0; axi.exu_awsize_i = 3'd3; axi.exu_awburst_i = 2'b01;
        axi.exu_wvalid_i  = 1'b1; axi.exu_wdata_i = {32'h5A5A_0000, addr};
        axi.exu_wstrb_i   = 8'hFF; axi.exu_wlast_i = 1'b1;
        axi.awready_i = 1'b0; axi.wready_i = 1'b1;
        axi.bvalid_i  = 1'b1; axi.bresp_i = c_resp_okay; axi.bid_i = id;
        axi.exu_bready_i = 1'b1;
        step();
        #1;
        check_val("aw_valid", axi.awvalid_o, 1);
        check_val("aw_addr", axi.awaddr_o, addr);
        check_val("w_valid", axi.wvalid_o, 1);
        check_val("w_data", axi.wdata_o, {32'h5A5A_0000, addr});
        check_val("w_ready_exu", axi.exu_wready_o, 1);
        check_val("b_early", axi.exu_bvalid_o, 0);
        step();
        axi.exu_wvalid_i = 1'b0;
        axi.exu_wlast_i  = 1'b0;
        for (int k = 1; k <= aw_delay; k++) begin
            axi.awready_i = (k == aw_delay);
            #1;
            check_val("aw_hold", axi.awvalid_o, 1);
            check_val("aw_ready_exu", axi.exu_awready_o, axi.awready_i);
            check_val("no_resp_before_aw", axi.exu_bvalid_o, 0);
            check_val("bready_before_aw", axi.bready_o, 0);
            step();
        end
        axi.exu_awvalid_i = 1'b0;
        axi.awready_i     = 1'b0;
        #1;
        check_val("b_valid", axi.exu_bvalid_o, 1);
        check_val("b_resp", axi.exu_bresp_o, c_resp_okay);
        check_val("b_id", axi.exu_bid_o, id);
        check_val("b_ready_bus", axi.bready_o, 1);
        check_val("aw_gated", axi.awvalid_o, 0);
        step();
        #1;
        check_val("b_released", axi.exu_bvalid_o, 0);
        axi.bvalid_i = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset   = 1'b0;
        set_ar(1'b0, 1'b1, 32'h0, 8'd0);
        set_ar(1'b1, 1'b1, 32'h0, 8'd0);
        axi.arready_i = 1'b1; axi.rvalid_i = 1'b1; axi.rdata_i = '1; axi.rresp_i = '0;
        axi.rlast_i = 1'b1; axi.rid_i = '0; axi.ifu_rready_i = 1'b1; axi.exu_rready_i = 1'b1;
        axi.exu_awvalid_i = 1'b1; axi.exu_awaddr_i = '0; axi.exu_awid_i = '0;
        axi.exu_awlen_i = '0; axi.exu_awsize_i = '0; axi.exu_awburst_i = '0;
        axi.awready_i = 1'b1; axi.exu_wvalid_i = 1'b1; axi.exu_wdata_i = '1;
        axi.exu_wstrb_i = '1; axi.exu_wlast_i = 1'b1; axi.wready_i = 1'b1;
        axi.bvalid_i = 1'b1; axi.bresp_i = c_resp_slverr; axi.bid_i = '0; axi.exu_bready_i = 1'b1;

        // Reset holds every output low even with all inputs active
        repeat (3) step();
        check_val("rst_arvalid", axi.arvalid_o, 0);
        check_val("rst_ifu_arready", axi.ifu_arready_o, 0);
        check_val("rst_ifu_rvalid", axi.ifu_rvalid_o, 0);
        check_val("rst_rready", axi.rready_o, 0);
        check_val("rst_awvalid", axi.awvalid_o, 0);
        check_val("rst_wvalid", axi.wvalid_o, 0);
        check_val("rst_bvalid", axi.exu_bvalid_o, 0);
        check_val("rst_rd_err", axi.rd_err_o, 0);
        set_ar(1'b0, 1'b0, 32'h0, 8'd0);
        set_ar(1'b1, 1'b0, 32'h0, 8'd0);
        axi.arready_i = 1'b0; axi.rvalid_i = 1'b0; axi.rlast_i = 1'b0;
        axi.exu_awvalid_i = 1'b0; axi.awready_i = 1'b0; axi.exu_wvalid_i = 1'b0;
        axi.exu_wlast_i = 1'b0; axi.wready_i = 1'b0; axi.bvalid_i = 1'b0;
        axi.bresp_i = c_resp_okay;
        reset = 1'b1;
        step();

        // Contention three times: IFU, EXU, IFU
        set_ar(1'b1, 1'b1, 32'h8000, 8'd0);
        rd_burst(1'b0, 8'd0, 1, 0, 32'h1000, errs);
        set_ar(1'b0, 1'b1, 32'h1000, 8'd0);
        rd_burst(1'b1, 8'd0, 1, 0, 32'h8000, errs);
        set_ar(1'b1, 1'b1, 32'h8000, 8'd0);
        rd_burst(1'b0, 8'd0, 1, 0, 32'h1000, errs);
        set_ar(1'b1, 1'b0, 32'h8000, 8'd0);
        step();

        // IFU-only 4-beat burst, correct length
        rd_burst(1'b0, 8'd3, 4, 0, 32'h1100, errs);
        check_val("len4_err_pulses", errs, 0);

        // arready held off 5 cycles: arvalid_o high for 6
        rd_burst(1'b0, 8'd0, 1, 5, 32'h1200, errs);
        check_val("arwait_err_pulses", errs, 0);

        // rlast on beat 2 of a 4-beat burst
        rd_burst(1'b0, 8'd3, 2, 0, 32'h1300, errs);
        check_val("early_rlast_pulses", errs, 1);

        // arlen=1 but rlast only on beat 3: missing-last then late-last
        rd_burst(1'b1, 8'd1, 3, 0, 32'h8100, errs);
        check_val("late_rlast_pulses", errs, 2);

        // EXU write with W completing 2 cycles before AW
        wr_txn(2, 32'h2000, 4'h5);

        // Same write overlapping an IFU read
        fork
            rd_burst(1'b0, 8'd1, 2, 0, 32'h1400, errs_w);
            wr_txn(2, 32'h2100, 4'h6);
        join
        check_val("overlap_err_pulses", errs_w, 0);
        step();

        // Asynchronous reset in the middle of an IFU data phase
        set_ar(1'b0, 1'b1, 32'h3000, 8'd3);
        axi.arready_i = 1'b1;
        step();
        step();
        set_ar(1'b0, 1'b0, 32'h3000, 8'd3);
        axi.arready_i = 1'b0;
        axi.rvalid_i = 1'b1; axi.rdata_i = 64'h1234; axi.rlast_i = 1'b0; axi.ifu_rready_i = 1'b1;
        #1;
        check_val("mid_burst_rvalid", axi.ifu_rvalid_o, 1);
        #2;
        reset = 1'b0;
        set_ar(1'b0, 1'b1, 32'h3000, 8'd0);
        set_ar(1'b1, 1'b1, 32'h8000, 8'd0);
        axi.arready_i = 1'b1;
        #1;
        check_val("async_rst_rvalid", axi.ifu_rvalid_o, 0);
        check_val("async_rst_rready", axi.rready_o, 0);
        check_val("async_rst_arvalid", axi.arvalid_o, 0);
        axi.rvalid_i = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        step();
        #1;
        check_val("post_rst_ifu_first", axi.ifu_arready_o, 1);
        check_val("post_rst_exu_wait", axi.exu_arready_o, 0);
        check_val("post_rst_araddr", axi.araddr_o, 32'h3000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
